int_ctrl: RTL and testbench

INT_CTRL -- requirements
Module: int_ctrl

---
 rtl/int_ctrl_pkg.sv | 23 ++
 rtl/int_ctrl_irq_prio.sv | 45 ++++
 rtl/int_ctrl.sv | 108 ++++++++++
 tb/tb_int_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/int_ctrl_pkg.sv
// Shared definitions for the exception/interrupt controller: FSM encoding,
// cause codes and the default exception vector.
package int_ctrl_pkg;

  typedef enum logic [1:0] {
    SUPER = 2'd0,
    TAKE  = 2'd1,
    USER  = 2'd2,
    RETN  = 2'd3
  } state_t;

  localparam logic [2:0]  CAUSE_NONE = 3'd0;
  localparam logic [2:0]  CAUSE_SW   = 3'd1;  // trap or store overflow
  localparam logic [2:0]  CAUSE_OVF  = 3'd2;
  localparam logic [2:0]  CAUSE_IRQ  = 3'd4;  // irq[i] reports CAUSE_IRQ + i

  localparam logic [31:0] VEC_BASE_DEF = 32'h0000_0100;

  function automatic logic [2:0] irq_cause(input logic [1:0] idx);
    return CAUSE_IRQ | {1'b0, idx};
  endfunction

endpackage

// File: rtl/int_ctrl_irq_prio.sv
// Interrupt pending latch plus fixed-priority encoder (irq[0] highest).
// Combinational hit/idx from pending|live lines; pending clears only on take.
module irq_prio #(
  parameter int NIRQ = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NIRQ-1:0] irq,
  input  logic [NIRQ-1:0] mask,
  input  logic            take,
  output logic            hit,
  output logic [1:0]      idx
);

  logic [NIRQ-1:0] pend_q;
  logic [NIRQ-1:0] eff;
  logic [NIRQ-1:0] clr;

  // Live lines count immediately so entry latency stays at one cycle.
  assign eff = (pend_q | irq) & mask;

  always_comb begin
    hit = 1'b0;
    idx = 2'd0;
    for (int i = NIRQ - 1; i >= 0; i--) begin
      if (eff[i]) begin
        hit = 1'b1;
        idx = 2'(i);
      end
    end
  end

  always_comb begin
    clr = '0;
    for (int i = 0; i < NIRQ; i++) begin
      if (take && hit && (idx == 2'(i))) clr[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pend_q <= '0;
    else        pend_q <= (pend_q | irq) & ~clr;
  end

endmodule

// File: rtl/int_ctrl.sv
// Exception/interrupt controller: takes events in USER mode, vectors to VEC_BASE,
// returns on rfe. One-cycle entry latency. IRQ_MASK_EN enables the irq mask register.
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter logic [31:0] VEC_BASE = VEC_BASE_DEF,
  parameter int          NIRQ     = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NIRQ-1:0] irq,
  input  logic            trap,
  input  logic            oint_ex,
  input  logic            memwrite,
  input  logic            rfe,
  input  logic            mask_we,
  input  logic [NIRQ-1:0] mask_wdata,
  output logic            s_u,
  output logic            exception,
  output logic            redirect,
  output logic [31:0]     vec_pc,
  output logic            flush,
  output logic            ret,
  output logic [2:0]      cause
);

  state_t          state_q;
  logic [NIRQ-1:0] mask;
  logic            sw_evt;
  logic            irq_hit;
  logic [1:0]      irq_idx;
  logic            take_irq;

`ifdef IRQ_MASK_EN
  logic [NIRQ-1:0] mask_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                           mask_q <= '1;
    else if (state_q == SUPER && mask_we) mask_q <= mask_wdata;
  end

  assign mask = mask_q;
`else
  logic unused_mask;

  assign mask        = '1;
  assign unused_mask = ^{mask_we, mask_wdata};
`endif

  assign sw_evt   = trap | (memwrite & oint_ex);
  assign take_irq = (state_q == USER) & ~sw_evt & ~oint_ex & irq_hit;
  assign vec_pc   = VEC_BASE;

  irq_prio #(.NIRQ(NIRQ)) u_irq_prio (
    .clk   (clk),
    .reset (reset),
    .irq   (irq),
    .mask  (mask),
    .take  (take_irq),
    .hit   (irq_hit),
    .idx   (irq_idx)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= SUPER;
      s_u       <= 1'b0;
      exception <= 1'b0;
      redirect  <= 1'b0;
      flush     <= 1'b0;
      ret       <= 1'b0;
      cause     <= CAUSE_NONE;
    end else begin
      exception <= 1'b0;
      redirect  <= 1'b0;
      flush     <= 1'b0;
      ret       <= 1'b0;
      case (state_q)
        USER: begin
          if (sw_evt || oint_ex || irq_hit) begin
            state_q   <= TAKE;
            s_u       <= 1'b0;
            exception <= 1'b1;
            redirect  <= 1'b1;
            flush     <= 1'b1;
            cause     <= sw_evt  ? CAUSE_SW  :
                         oint_ex ? CAUSE_OVF : irq_cause(irq_idx);
          end
        end
        TAKE: state_q <= SUPER;
        SUPER: begin
          // rfe wins over any coincident event; events are re-seen in USER.
          if (rfe) begin
            state_q <= RETN;
            ret     <= 1'b1;
            flush   <= 1'b1;
          end
        end
        RETN: begin
          state_q <= USER;
          s_u     <= 1'b1;
        end
        default: state_q <= SUPER;
      endcase
    end
  end

endmodule

// File: tb/tb_int_ctrl.sv
// Bench for int_ctrl: directed scenarios then random traffic against a
// mode-level reference model (build with or without IRQ_MASK_EN).
module tb_int_ctrl;

  localparam int NIRQ = 4;
`ifdef IRQ_MASK_EN
  localparam bit MASK_EN = 1'b1;
`else
  localparam bit MASK_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic [NIRQ-1:0] irq;
  logic            trap, oint_ex, memwrite, rfe, mask_we;
  logic [NIRQ-1:0] mask_wdata;
  logic            s_u, exception, redirect, flush, ret;
  logic [31:0]     vec_pc;
  logic [2:0]      cause;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: the observable mode plus pending/mask sets.
  bit m_su, m_exc, m_red, m_flush, m_ret;
  int m_cause;
  bit m_pend [NIRQ];
  bit m_mask [NIRQ];

  always #5 clk = ~clk;

  int_ctrl #(.VEC_BASE(32'h0000_0100), .NIRQ(NIRQ)) dut (
    .clk        (clk),
    .reset      (reset),
    .irq        (irq),
    .trap       (trap),
    .oint_ex    (oint_ex),
    .memwrite   (memwrite),
    .rfe        (rfe),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .s_u        (s_u),
    .exception  (exception),
    .redirect   (redirect),
    .vec_pc     (vec_pc),
    .flush      (flush),
    .ret        (ret),
    .cause      (cause)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic clear_in();
    irq = '0; trap = 0; oint_ex = 0; memwrite = 0; rfe = 0;
    mask_we = 0; mask_wdata = '0;
  endtask

  task automatic mdl_reset();
    m_su = 0; m_exc = 0; m_red = 0; m_flush = 0; m_ret = 0; m_cause = 0;
    for (int i = 0; i < NIRQ; i++) begin
      m_pend[i] = 0;
      m_mask[i] = 1;
    end
  endtask

  // One clock of the specified behaviour, evaluated from the inputs at the edge.
  task automatic mdl_step();
    bit in_user, in_take, in_retn;
    int c;
    in_user = m_su;
    in_take = m_exc;
    in_retn = m_ret;
    c = -1;
    for (int i = 0; i < NIRQ; i++) if (irq[i]) m_pend[i] = 1;
    m_exc = 0; m_red = 0; m_flush = 0; m_ret = 0;
    if (in_user) begin
      if (trap || (memwrite && oint_ex)) c = 1;
      else if (oint_ex)                  c = 2;
      else begin
        for (int i = 0; i < NIRQ; i++) begin
          if (c < 0 && m_pend[i] && m_mask[i]) begin
            c = 4 + i;
            m_pend[i] = 0;
          end
        end
      end
      if (c >= 0) begin
        m_su = 0; m_exc = 1; m_red = 1; m_flush = 1; m_cause = c;
      end
    end else if (in_retn) begin
      m_su = 1;
    end else if (!in_take) begin
      if (rfe) begin
        m_ret = 1; m_flush = 1;
      end
      if (MASK_EN && mask_we)
        for (int i = 0; i < NIRQ; i++) m_mask[i] = mask_wdata[i];
    end
  endtask

  task automatic check_outs();
    chk("s_u",       s_u,       m_su);
    chk("exception", exception, m_exc);
    chk("redirect",  redirect,  m_red);
    chk("flush",     flush,     m_flush);
    chk("ret",       ret,       m_ret);
    chk("cause",     cause,     m_cause);
    chk("vec_pc",    vec_pc,    32'h0000_0100);
  endtask

  task automatic step();
    @(posedge clk);
    mdl_step();
    #1;
    check_outs();
  endtask

  task automatic go_user();
    for (int k = 0; k < 8 && !m_su; k++) begin
      rfe = 1;
      step();
    end
    rfe = 0;
    chk("reach_user", s_u, 1);
  endtask

  initial begin
    clear_in();
    reset = 0;
    mdl_reset();
    #2;
    check_outs();
    @(negedge clk);
    reset = 1;

    // Idle after reset stays supervisor; rfe returns to user.
    step();
    chk("r034_su0", s_u, 0);
    rfe = 1; step(); rfe = 0;
    chk("r034_ret", ret, 1);
    step();
    chk("r034_su1", s_u, 1);
    chk("r034_ret0", ret, 0);

    // Trap entry.
    trap = 1; step(); trap = 0;
    chk("r035_exc",   exception, 1);
    chk("r035_red",   redirect,  1);
    chk("r035_vec",   vec_pc,    32'h100);
    chk("r035_cause", cause,     1);
    step();
    chk("r035_super", {s_u, exception, redirect}, 0);

    // Store overflow vs plain overflow.
    go_user();
    oint_ex = 1; memwrite = 1; step(); clear_in();
    chk("r036_stov", cause, 1);
    step();
    go_user();
    oint_ex = 1; step(); clear_in();
    chk("r036_ovf", cause, 2);
    step();

    // Two irqs: lower index first, the other stays pending across the return.
    go_user();
    irq = 4'b0110; step(); irq = '0;
    chk("r037_c5", cause, 5);
    step();
    go_user();
    step();
    chk("r037_c6",  cause,     6);
    chk("r037_exc", exception, 1);
    step();

    // Mask write in SUPER, then an irq on a masked line.
    mask_we = 1; mask_wdata = 4'b1101; rfe = 1; step(); clear_in();
    step();
    chk("r038_user", s_u, 1);
    irq = 4'b0010; step(); irq = '0;
    chk("r038_exc",   exception, MASK_EN ? 32'd0 : 32'd1);
    chk("r038_cause", cause,     MASK_EN ? 32'd6 : 32'd5);
    step();

    // Reset pulsed mid-TAKE.
    go_user();
    trap = 1; step(); trap = 0;
    chk("r039_take", exception, 1);
    #2 reset = 0;
    #1;
    chk("r039_exc",   exception, 0);
    chk("r039_red",   redirect,  0);
    chk("r039_flush", flush,     0);
    chk("r039_ret",   ret,       0);
    chk("r039_su",    s_u,       0);
    chk("r039_cause", cause,     0);
    mdl_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1;
    step();
    chk("r039_noexc", exception, 0);
    step();
    chk("r039_nored", redirect, 0);

    // Event coincident with rfe in SUPER: rfe wins.
    trap = 1; rfe = 1; step(); rfe = 0; trap = 0;
    chk("r025_ret", ret,       1);
    chk("r025_exc", exception, 0);
    step();

    // Random traffic.
    for (int n = 0; n < 800; n++) begin
      rfe        = ($urandom_range(2) == 0);
      trap       = ($urandom_range(15) == 0);
      oint_ex    = ($urandom_range(15) == 0);
      memwrite   = ($urandom_range(3) == 0);
      mask_we    = ($urandom_range(7) == 0);
      mask_wdata = 4'($urandom_range(15));
      for (int i = 0; i < NIRQ; i++) irq[i] = ($urandom_range(11) == 0);
      step();
    end
    clear_in();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
